// File: rtl/irrigation_scheduler.sv
// Irrigation cycle sequencer: IDLE -> FILL -> IRRIGATE -> CLEAN -> IDLE, timed from a 1 Hz enable
// with a two-digit BCD countdown, fill timeout, pause/resume on empty tank and pesticide cleaning.
module irrigation_scheduler #(
    parameter int FILL_MAX_S  = 30,
    parameter int SPRINKLER_S = 20,
    parameter int DRIP_S      = 30,
    parameter int CLEAN_S     = 10
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] irr_type,
    input  logic       tank_full,
    input  logic       tank_empty,
    input  logic       pesticide,
    output logic [1:0] state_o,
    output logic       valve_fill,
    output logic       valve_sprinkler,
    output logic       valve_drip,
    output logic       valve_clean,
    output logic [1:0] ds_o,
    output logic [3:0] us_o,
    output logic       done_o,
    output logic       fault_o,
    output logic       alert_np_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_FILL     = 2'b01,
        S_IRRIGATE = 2'b10,
        S_CLEAN    = 2'b11
    } state_t;

    typedef struct packed {
        logic [1:0] tens;
        logic [3:0] units;
    } bcd_t;

    function automatic bcd_t to_bcd(input int v);
        bcd_t r;
        r.tens  = 2'(v / 10);
        r.units = 4'(v % 10);
        return r;
    endfunction

    // Saturates at 00 so a stray tick can never wrap the display.
    function automatic bcd_t bcd_dec(input bcd_t c);
        bcd_t r;
        r = c;
        if (c.units != 4'd0) begin
            r.units = c.units - 4'd1;
        end else if (c.tens != 2'd0) begin
            r.tens  = c.tens - 2'd1;
            r.units = 4'd9;
        end
        return r;
    endfunction

    localparam bcd_t FILL_BCD   = to_bcd(FILL_MAX_S);
    localparam bcd_t SPR_BCD    = to_bcd(SPRINKLER_S);
    localparam bcd_t DRIP_BCD   = to_bcd(DRIP_S);
    localparam bcd_t CLEAN_BCD  = to_bcd(CLEAN_S);
    localparam bcd_t CLEAN2_BCD = to_bcd(2 * CLEAN_S);
    localparam bcd_t BCD_ONE    = '{tens: 2'd0, units: 4'd1};
    localparam bcd_t BCD_ZERO   = '{tens: 2'd0, units: 4'd0};

    state_t state_q, state_d;
    bcd_t   cnt_q, cnt_d, saved_q, saved_d;
    logic   paused_q, paused_d;
    logic   spr_q, spr_d;
    logic   pest_q, pest_d;
    logic   done_q, done_d;
    logic   fault_q, fault_d;
    logic   alert_q, alert_d;
    bcd_t   clean_load;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= BCD_ZERO;
            saved_q  <= BCD_ZERO;
            paused_q <= 1'b0;
            spr_q    <= 1'b0;
            pest_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            alert_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            saved_q  <= saved_d;
            paused_q <= paused_d;
            spr_q    <= spr_d;
            pest_q   <= pest_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            alert_q  <= alert_d;
        end
    end

    assign clean_load = pest_q ? CLEAN2_BCD : CLEAN_BCD;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        saved_d  = saved_q;
        paused_d = paused_q;
        spr_d    = spr_q;
        pest_d   = pest_q;
        done_d   = 1'b0;
        fault_d  = fault_q;
        alert_d  = alert_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (irr_type == 2'b10 && pesticide) begin
                        alert_d = 1'b1;
                    end else if (irr_type == 2'b01 || irr_type == 2'b10) begin
                        state_d  = S_FILL;
                        spr_d    = irr_type[1];
                        pest_d   = pesticide;
                        fault_d  = 1'b0;
                        alert_d  = 1'b0;
                        paused_d = 1'b0;
                        cnt_d    = FILL_BCD;
                    end
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    cnt_d    = BCD_ZERO;
                    paused_d = 1'b0;
                end else if (tank_full) begin
                    // A refill after an empty tank resumes the interrupted irrigation time.
                    state_d  = S_IRRIGATE;
                    cnt_d    = paused_q ? saved_q : (spr_q ? SPR_BCD : DRIP_BCD);
                    paused_d = 1'b0;
                end else if (tick_1hz) begin
                    if (cnt_q == BCD_ONE) begin
                        state_d  = S_IDLE;
                        cnt_d    = BCD_ZERO;
                        fault_d  = 1'b1;
                        paused_d = 1'b0;
                    end else begin
                        cnt_d = bcd_dec(cnt_q);
                    end
                end
            end
            S_IRRIGATE: begin
                if (abort) begin
                    state_d = S_CLEAN;
                    cnt_d   = clean_load;
                end else if (tank_empty) begin
                    state_d  = S_FILL;
                    saved_d  = cnt_q;
                    paused_d = 1'b1;
                    cnt_d    = FILL_BCD;
                end else if (tick_1hz) begin
                    if (cnt_q == BCD_ONE) begin
                        state_d = S_CLEAN;
                        cnt_d   = clean_load;
                    end else begin
                        cnt_d = bcd_dec(cnt_q);
                    end
                end
            end
            S_CLEAN: begin
                if (tick_1hz) begin
                    if (cnt_q == BCD_ONE) begin
                        state_d = S_IDLE;
                        cnt_d   = BCD_ZERO;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = bcd_dec(cnt_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_o         = state_q;
    assign ds_o            = cnt_q.tens;
    assign us_o            = cnt_q.units;
    assign done_o          = done_q;
    assign fault_o         = fault_q;
    assign alert_np_o      = alert_q;
    assign valve_fill      = (state_q == S_FILL);
    assign valve_sprinkler = (state_q == S_IRRIGATE) && spr_q;
    assign valve_drip      = (state_q == S_IRRIGATE) && !spr_q;
    assign valve_clean     = (state_q == S_CLEAN);

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler: drip, sprinkler pause/resume, pesticide reject,
// fill timeout, abort priorities and reset during CLEAN, with hand-computed expectations.
module tb_irrigation_scheduler;

    logic       clk_50mhz = 1'b0;
    logic       rst, tick_1hz, start, abort, tank_full, tank_empty, pesticide;
    logic [1:0] irr_type;
    logic [1:0] state_o, ds_o;
    logic [3:0] us_o;
    logic       valve_fill, valve_sprinkler, valve_drip, valve_clean;
    logic       done_o, fault_o, alert_np_o;

    int tests = 0;
    int fails = 0;

    irrigation_scheduler dut (
        .clk_50mhz      (clk_50mhz),
        .rst            (rst),
        .tick_1hz       (tick_1hz),
        .start          (start),
        .abort          (abort),
        .irr_type       (irr_type),
        .tank_full      (tank_full),
        .tank_empty     (tank_empty),
        .pesticide      (pesticide),
        .state_o        (state_o),
        .valve_fill     (valve_fill),
        .valve_sprinkler(valve_sprinkler),
        .valve_drip     (valve_drip),
        .valve_clean    (valve_clean),
        .ds_o           (ds_o),
        .us_o           (us_o),
        .done_o         (done_o),
        .fault_o        (fault_o),
        .alert_np_o     (alert_np_o)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic tick_n(input int n);
        tick_1hz = 1'b1;
        repeat (n) step();
        tick_1hz = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] t, input logic p);
        irr_type  = t;
        pesticide = p;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic pulse_full();
        tank_full = 1'b1;
        step();
        tank_full = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick_1hz = 0; start = 0; abort = 0; irr_type = 2'b00;
        tank_full = 0; tank_empty = 0; pesticide = 0;
        step(); step();
        rst = 1'b0;
        step();
        tests++;
        if ({state_o, ds_o, us_o, valve_fill, valve_sprinkler, valve_drip, valve_clean,
             done_o, fault_o, alert_np_o} !== 15'd0) begin
            fails++;
            $display("FAIL reset_state got=%b exp=%b", {state_o, ds_o, us_o, valve_fill,
                     valve_sprinkler, valve_drip, valve_clean, done_o, fault_o, alert_np_o}, 15'd0);
        end
    endtask

    task automatic test_drip_cycle();
        pulse_start(2'b01, 1'b0);
        tests++;
        if ({state_o, ds_o, us_o, valve_fill} !== {2'b01, 2'd3, 4'd0, 1'b1}) begin
            fails++; $display("FAIL drip_fill_entry got=%b exp=%b", {state_o, ds_o, us_o, valve_fill}, {2'b01, 2'd3, 4'd0, 1'b1});
        end
        tick_n(5);
        tests++;
        if ({state_o, ds_o, us_o} !== {2'b01, 2'd2, 4'd5}) begin
            fails++; $display("FAIL drip_fill_count got=%b exp=%b", {state_o, ds_o, us_o}, {2'b01, 2'd2, 4'd5});
        end
        pulse_full();
        tests++;
        if ({state_o, ds_o, us_o, valve_fill, valve_sprinkler, valve_drip, valve_clean} !== {2'b10, 2'd3, 4'd0, 4'b0010}) begin
            fails++; $display("FAIL drip_irrigate_entry got=%b exp=%b", {state_o, ds_o, us_o, valve_fill, valve_sprinkler, valve_drip, valve_clean}, {2'b10, 2'd3, 4'd0, 4'b0010});
        end
        tick_n(29);
        tests++;
        if ({state_o, ds_o, us_o} !== {2'b10, 2'd0, 4'd1}) begin
            fails++; $display("FAIL drip_irrigate_last got=%b exp=%b", {state_o, ds_o, us_o}, {2'b10, 2'd0, 4'd1});
        end
        tick_n(1);
        tests++;
        if ({state_o, ds_o, us_o, valve_fill, valve_sprinkler, valve_drip, valve_clean} !== {2'b11, 2'd1, 4'd0, 4'b0001}) begin
            fails++; $display("FAIL drip_clean_entry got=%b exp=%b", {state_o, ds_o, us_o, valve_fill, valve_sprinkler, valve_drip, valve_clean}, {2'b11, 2'd1, 4'd0, 4'b0001});
        end
        tick_n(9);
        tests++;
        if ({state_o, ds_o, us_o, done_o} !== {2'b11, 2'd0, 4'd1, 1'b0}) begin
            fails++; $display("FAIL drip_clean_last got=%b exp=%b", {state_o, ds_o, us_o, done_o}, {2'b11, 2'd0, 4'd1, 1'b0});
        end
        tick_n(1);
        tests++;
        if ({state_o, ds_o, us_o, done_o, valve_clean} !== {2'b00, 2'd0, 4'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL drip_done got=%b exp=%b", {state_o, ds_o, us_o, done_o, valve_clean}, {2'b00, 2'd0, 4'd0, 1'b1, 1'b0});
        end
        step();
        tests++;
        if (done_o !== 1'b0) begin
            fails++; $display("FAIL drip_done_one_cycle got=%b exp=%b", done_o, 1'b0);
        end
    endtask

    task automatic test_pesticide_reject();
        pulse_start(2'b10, 1'b1);
        tests++;
        if ({state_o, alert_np_o, valve_fill, valve_sprinkler, valve_drip, valve_clean} !== {2'b00, 1'b1, 4'b0000}) begin
            fails++; $display("FAIL np_reject got=%b exp=%b", {state_o, alert_np_o, valve_fill, valve_sprinkler, valve_drip, valve_clean}, {2'b00, 1'b1, 4'b0000});
        end
        pulse_start(2'b01, 1'b1);
        irr_type = 2'b10;
        tests++;
        if ({state_o, alert_np_o} !== {2'b01, 1'b0}) begin
            fails++; $display("FAIL np_accept_clears got=%b exp=%b", {state_o, alert_np_o}, {2'b01, 1'b0});
        end
        pulse_full();
        tests++;
        if ({state_o, valve_sprinkler, valve_drip} !== {2'b10, 1'b0, 1'b1}) begin
            fails++; $display("FAIL np_latched_type got=%b exp=%b", {state_o, valve_sprinkler, valve_drip}, {2'b10, 1'b0, 1'b1});
        end
        abort = 1'b1; step(); abort = 1'b0;
        tests++;
        if ({state_o, ds_o, us_o} !== {2'b11, 2'd2, 4'd0}) begin
            fails++; $display("FAIL np_double_clean got=%b exp=%b", {state_o, ds_o, us_o}, {2'b11, 2'd2, 4'd0});
        end
        tick_n(20);
        tests++;
        if ({state_o, done_o} !== {2'b00, 1'b1}) begin
            fails++; $display("FAIL np_clean_done got=%b exp=%b", {state_o, done_o}, {2'b00, 1'b1});
        end
        irr_type = 2'b00; pesticide = 1'b0;
        step();
    endtask

    task automatic test_fill_timeout();
        pulse_start(2'b01, 1'b0);
        tick_n(29);
        tests++;
        if ({state_o, ds_o, us_o} !== {2'b01, 2'd0, 4'd1}) begin
            fails++; $display("FAIL timeout_last got=%b exp=%b", {state_o, ds_o, us_o}, {2'b01, 2'd0, 4'd1});
        end
        tick_n(1);
        tests++;
        if ({state_o, ds_o, us_o, fault_o, done_o} !== {2'b00, 2'd0, 4'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL timeout_fault got=%b exp=%b", {state_o, ds_o, us_o, fault_o, done_o}, {2'b00, 2'd0, 4'd0, 1'b1, 1'b0});
        end
        pulse_start(2'b11, 1'b0);
        tests++;
        if ({state_o, fault_o} !== {2'b00, 1'b1}) begin
            fails++; $display("FAIL invalid_type_ignored got=%b exp=%b", {state_o, fault_o}, {2'b00, 1'b1});
        end
        pulse_start(2'b01, 1'b0);
        tests++;
        if ({state_o, fault_o} !== {2'b01, 1'b0}) begin
            fails++; $display("FAIL restart_clears_fault got=%b exp=%b", {state_o, fault_o}, {2'b01, 1'b0});
        end
        tick_n(29);
        tank_full = 1'b1; tick_1hz = 1'b1; step(); tank_full = 1'b0; tick_1hz = 1'b0;
        tests++;
        if ({state_o, ds_o, us_o, fault_o} !== {2'b10, 2'd3, 4'd0, 1'b0}) begin
            fails++; $display("FAIL full_beats_timeout got=%b exp=%b", {state_o, ds_o, us_o, fault_o}, {2'b10, 2'd3, 4'd0, 1'b0});
        end
        abort = 1'b1; step(); abort = 1'b0;
        tick_n(10);
        pulse_start(2'b01, 1'b0);
        abort = 1'b1; tank_empty = 1'b1; step(); abort = 1'b0; tank_empty = 1'b0;
        tests++;
        if ({state_o, done_o, fault_o, valve_fill} !== {2'b00, 1'b0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL fill_abort got=%b exp=%b", {state_o, done_o, fault_o, valve_fill}, {2'b00, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_sprinkler_resume();
        pulse_start(2'b10, 1'b0);
        pulse_full();
        tests++;
        if ({state_o, ds_o, us_o, valve_sprinkler, valve_drip} !== {2'b10, 2'd2, 4'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL spr_entry got=%b exp=%b", {state_o, ds_o, us_o, valve_sprinkler, valve_drip}, {2'b10, 2'd2, 4'd0, 1'b1, 1'b0});
        end
        tick_n(12);
        tests++;
        if ({ds_o, us_o} !== {2'd0, 4'd8}) begin
            fails++; $display("FAIL spr_count got=%b exp=%b", {ds_o, us_o}, {2'd0, 4'd8});
        end
        tank_empty = 1'b1; tick_1hz = 1'b1; step(); tank_empty = 1'b0; tick_1hz = 1'b0;
        tests++;
        if ({state_o, ds_o, us_o, valve_fill, valve_sprinkler} !== {2'b01, 2'd3, 4'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL spr_pause got=%b exp=%b", {state_o, ds_o, us_o, valve_fill, valve_sprinkler}, {2'b01, 2'd3, 4'd0, 1'b1, 1'b0});
        end
        tick_n(3);
        pulse_full();
        tests++;
        if ({state_o, ds_o, us_o, valve_sprinkler} !== {2'b10, 2'd0, 4'd8, 1'b1}) begin
            fails++; $display("FAIL spr_resume got=%b exp=%b", {state_o, ds_o, us_o, valve_sprinkler}, {2'b10, 2'd0, 4'd8, 1'b1});
        end
        abort = 1'b1; tank_empty = 1'b1; step(); abort = 1'b0; tank_empty = 1'b0;
        tests++;
        if ({state_o, ds_o, us_o, done_o} !== {2'b11, 2'd1, 4'd0, 1'b0}) begin
            fails++; $display("FAIL abort_beats_empty got=%b exp=%b", {state_o, ds_o, us_o, done_o}, {2'b11, 2'd1, 4'd0, 1'b0});
        end
        abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
        tests++;
        if ({state_o, ds_o, us_o} !== {2'b11, 2'd1, 4'd0}) begin
            fails++; $display("FAIL clean_ignores_abort_start got=%b exp=%b", {state_o, ds_o, us_o}, {2'b11, 2'd1, 4'd0});
        end
        tick_n(9);
        tests++;
        if ({state_o, done_o} !== {2'b11, 1'b0}) begin
            fails++; $display("FAIL abort_no_early_done got=%b exp=%b", {state_o, done_o}, {2'b11, 1'b0});
        end
        tick_n(1);
        tests++;
        if ({state_o, done_o} !== {2'b00, 1'b1}) begin
            fails++; $display("FAIL abort_clean_done got=%b exp=%b", {state_o, done_o}, {2'b00, 1'b1});
        end
        step();
    endtask

    task automatic test_reset_mid_clean();
        pulse_start(2'b01, 1'b0);
        pulse_full();
        abort = 1'b1; step(); abort = 1'b0;
        tick_n(3);
        tests++;
        if ({state_o, ds_o, us_o} !== {2'b11, 2'd0, 4'd7}) begin
            fails++; $display("FAIL pre_reset_clean got=%b exp=%b", {state_o, ds_o, us_o}, {2'b11, 2'd0, 4'd7});
        end
        rst = 1'b1; tick_1hz = 1'b1; step(); rst = 1'b0; tick_1hz = 1'b0;
        tests++;
        if ({state_o, ds_o, us_o, valve_fill, valve_sprinkler, valve_drip, valve_clean,
             done_o, fault_o, alert_np_o} !== 15'd0) begin
            fails++;
            $display("FAIL reset_mid_clean got=%b exp=%b", {state_o, ds_o, us_o, valve_fill,
                     valve_sprinkler, valve_drip, valve_clean, done_o, fault_o, alert_np_o}, 15'd0);
        end
    endtask

    initial begin
        test_reset();
        test_drip_cycle();
        test_pesticide_reject();
        test_fill_timeout();
        test_sprinkler_resume();
        test_reset_mid_clean();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Central sequencer of the automated irrigation system: walks one irrigation cycle IDLE -> FILL -> IRRIGATE -> CLEAN -> IDLE.
- Drives the fill, sprinkler, drip and clean valve enables, a BCD countdown for the display and the 2-bit state code used by the display and line logic.
- Times everything from a 1 Hz tick enable, enforces a fill timeout and performs mandatory post-pesticide cleaning.

Parameters:
- FILL_MAX_S, 30, seconds allowed to reach tank full before fault (1..39)
- SPRINKLER_S, 20, sprinkler irrigation duration in seconds (1..39)
- DRIP_S, 30, drip irrigation duration in seconds (1..39)
- CLEAN_S, 10, base cleaning duration in seconds (1..19; doubled after pesticide)

Ports:
- clk_50mhz  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_1hz  in  1  one-cycle enable pulse, once per second, synchronous to clk_50mhz
- start  in  1  one-cycle start request (debounced)
- abort  in  1  one-cycle abort request
- irr_type  in  2  00 none, 01 drip, 10 sprinkler, 11 invalid (treated as none)
- tank_full  in  1  level sensor, tank full
- tank_empty  in  1  level sensor, tank empty
- pesticide  in  1  pesticide injection selected
- state_o  out  2  00 IDLE, 01 FILL, 10 IRRIGATE, 11 CLEAN
- valve_fill, valve_sprinkler, valve_drip, valve_clean  out  1 each  valve enables
- ds_o  out  2  remaining seconds, BCD tens
- us_o  out  4  remaining seconds, BCD units
- done_o  out  1  one-cycle pulse on normal cycle completion
- fault_o  out  1  sticky fill-timeout fault
- alert_np_o  out  1  sticky: start rejected (pesticide with sprinkler)

Behaviour:
- Reset: state IDLE; all valves 0; ds_o=0, us_o=0; done_o=0; fault_o=0; alert_np_o=0; internal type and pesticide latches cleared. Reset overrides every other input in the same cycle.
- All outputs are registered and change one cycle after the causing input edge.
- IDLE: start with irr_type in {01,10} and NOT (pesticide AND irr_type=10) -> FILL.
  - On acceptance: latch irr_type and pesticide; clear fault_o and alert_np_o; load the counter with FILL_MAX_S.
  - start with pesticide=1 and irr_type=10: stay in IDLE, set alert_np_o.
  - start with irr_type 00 or 11: ignored, no flag change.
- FILL: valve_fill=1.
  - tank_full=1 -> IRRIGATE; load the counter with DRIP_S or SPRINKLER_S per the latched type.
  - Otherwise, on each tick decrement the counter. A tick while the counter is 1 -> IDLE with fault_o=1 and counter 0.
  - tank_full has priority over the timeout tick in the same cycle.
- IRRIGATE: valve_drip or valve_sprinkler per the latched type.
  - Each tick decrements the counter. A tick at 1 -> CLEAN; load CLEAN_S, or 2*CLEAN_S if the latched pesticide is 1.
  - tank_empty=1 (no abort) -> FILL with the irrigation counter saved and FILL_MAX_S loaded.
  - On the later FILL->IRRIGATE transition, restore the saved count (pause and resume, not restart).
- CLEAN: valve_clean=1. Each tick decrements; a tick at 1 -> IDLE with counter 0 and done_o pulsed one cycle. abort is ignored.
- abort:
  - In FILL -> IDLE, no done_o, no fault.
  - In IRRIGATE -> CLEAN, with cleaning loaded as on normal completion.
  - Priority in IRRIGATE: abort > tank_empty > tick.
- Counter is two-digit BCD (tens 0..3, units 0..9). Decrement wraps units 0 -> 9 with tens -1. The counter never decrements below 0. ds_o/us_o always reflect the live counter.
- At most one valve is 1 in any cycle. The valves are a pure function of the registered state and the latched type.
- start outside IDLE is ignored. Changes to irr_type or pesticide after acceptance have no effect until the next cycle.

Test Plan:
- rst, irr_type=01, pesticide=0, start; tank_full after 5 ticks -> state 01 (ds/us 3/0 counting to 2/5), then 10 with 3/0. After 30 ticks -> 11 with 1/0; after 10 ticks -> 00, done_o for exactly one cycle, valve_drip active only during 10.
- irr_type=10, pesticide=1, start -> state stays 00, alert_np_o=1, all valves 0. Then irr_type=01 and start -> FILL accepted, alert_np_o cleared; CLEAN later loads 2/0.
- tank_full never asserted -> after 30 ticks state 00 and fault_o=1. The next accepted start clears fault_o.
- Sprinkler run with 12 ticks elapsed (counter 0/8), then tank_empty -> state 01. tank_full -> state 10 with counter 0/8 resumed.
- In IRRIGATE, abort and tank_empty in the same cycle -> CLEAN (11) with 1/0; done_o occurs only after the clean finishes. Repeat in FILL -> 00 with no done_o.
- rst asserted mid-CLEAN together with a tick -> next cycle state 00, valves 0, ds/us 0/0, no done_o.
